// File: rtl/motoro301_pkg.sv
// Shared types and defaults for the motoro301 dead-time / gate-drive stage.
package motoro301_pkg;

    localparam int DEAD_CYC_DEF = 50;
    localparam int CNT_W_DEF    = 8;
    localparam int NUM_PH       = 3;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DT_HI = 3'd1,
        ST_HI    = 3'd2,
        ST_DT_LO = 3'd3,
        ST_LO    = 3'd4
    } phase_state_e;

    typedef struct packed {
        logic hp;    // high-side drive, active-low
        logic ln;    // low-side drive, active-high
        logic dead;  // leg inside a dead interval
    } gate_t;

    localparam gate_t GATE_OFF = '{hp: 1'b1, ln: 1'b0, dead: 1'b0};

    // Only HI turns the high side on and only LO turns the low side on,
    // so no state can ever drive both switches of a leg.
    function automatic gate_t decode_gate(input phase_state_e st);
        gate_t g;
        g.hp   = (st != ST_HI);
        g.ln   = (st == ST_LO);
        g.dead = (st == ST_DT_HI) || (st == ST_DT_LO);
        return g;
    endfunction

endpackage

// File: rtl/motoro301_deadtime_phase.sv
// One inverter leg: OFF/DT_HI/HI/DT_LO/LO FSM, dead-time counter, registered gate decode.
module motoro301_deadtime_phase
    import motoro301_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk50mhz,
    input  logic nReset,
    input  logic en,
    input  logic cmd,
    output logic hp,
    output logic ln,
    output logic dead_act
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYC - 1);

    phase_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    gate_t            gate_q;

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            state  <= ST_OFF;
            cnt    <= '0;
            gate_q <= GATE_OFF;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gate_q <= decode_gate(state_nxt);
        end
    end

    // A reversal inside a dead interval reloads the counter, so every turn-on
    // is preceded by a full DEAD_CYC of both-off regardless of history.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = cmd ? ST_DT_HI : ST_DT_LO;
                    cnt_nxt   = RELOAD;
                end
                ST_DT_HI: begin
                    if (!cmd) begin
                        state_nxt = ST_DT_LO;
                        cnt_nxt   = RELOAD;
                    end else if (cnt == '0) begin
                        state_nxt = ST_HI;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_DT_LO: begin
                    if (cmd) begin
                        state_nxt = ST_DT_HI;
                        cnt_nxt   = RELOAD;
                    end else if (cnt == '0) begin
                        state_nxt = ST_LO;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_HI: begin
                    if (!cmd) begin
                        state_nxt = ST_DT_LO;
                        cnt_nxt   = RELOAD;
                    end
                end
                ST_LO: begin
                    if (cmd) begin
                        state_nxt = ST_DT_HI;
                        cnt_nxt   = RELOAD;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign hp       = gate_q.hp;
    assign ln       = gate_q.ln;
    assign dead_act = gate_q.dead;

endmodule

// File: rtl/motoro301_deadtime.sv
// Three-phase dead-time insertion and gate drive. Optional shoot-through checker
// compiled in with SHOOT_THROUGH_CHECK_EN.
module motoro301_deadtime
    import motoro301_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk50mhz,
    input  logic       nReset,
    input  logic       outEn,
    input  logic [2:0] phCmd,
    output logic       aHP,
    output logic       bHP,
    output logic       cHP,
    output logic       aLN,
    output logic       bLN,
    output logic       cLN,
    output logic [2:0] deadAct,
    output logic       fault
);

    logic [NUM_PH-1:0] hp_raw, ln_raw, dead_raw;
    logic [NUM_PH-1:0] hp, ln, dead;

    for (genvar i = 0; i < NUM_PH; i++) begin : g_ph
        motoro301_deadtime_phase #(
            .DEAD_CYC(DEAD_CYC),
            .CNT_W   (CNT_W)
        ) u_phase (
            .clk50mhz(clk50mhz),
            .nReset  (nReset),
            .en      (outEn),
            .cmd     (phCmd[i]),
            .hp      (hp_raw[i]),
            .ln      (ln_raw[i]),
            .dead_act(dead_raw[i])
        );
    end

`ifdef SHOOT_THROUGH_CHECK_EN
    // Watches the registered leg outputs independently of the FSMs; once
    // tripped, only nReset can release the bridge.
    logic fault_q;

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset)
            fault_q <= 1'b0;
        else if (|(~hp_raw & ln_raw))
            fault_q <= 1'b1;
    end

    assign fault = fault_q;
    assign hp    = fault_q ? '1 : hp_raw;
    assign ln    = fault_q ? '0 : ln_raw;
    assign dead  = fault_q ? '0 : dead_raw;
`else
    assign fault = 1'b0;
    assign hp    = hp_raw;
    assign ln    = ln_raw;
    assign dead  = dead_raw;
`endif

    assign aHP     = hp[0];
    assign bHP     = hp[1];
    assign cHP     = hp[2];
    assign aLN     = ln[0];
    assign bLN     = ln[1];
    assign cLN     = ln[2];
    assign deadAct = dead;

endmodule

// File: tb/tb_motoro301_deadtime.sv
// Self-checking bench for motoro301_deadtime: run-length reference model plus directed timing scenarios.
module tb_motoro301_deadtime;

    localparam int D = 50;

    logic       clk50mhz = 1'b0;
    logic       nReset   = 1'b0;
    logic       outEn    = 1'b0;
    logic [2:0] phCmd    = 3'b000;
    logic       aHP, bHP, cHP, aLN, bLN, cLN;
    logic [2:0] deadAct;
    logic       fault;

    int checks = 0;
    int errors = 0;
    bit clk_run = 1'b1;

    always begin
        #10;
        if (clk_run) clk50mhz = ~clk50mhz;
    end

    motoro301_deadtime #(.DEAD_CYC(D), .CNT_W(8)) dut (
        .clk50mhz(clk50mhz),
        .nReset  (nReset),
        .outEn   (outEn),
        .phCmd   (phCmd),
        .aHP     (aHP),
        .bHP     (bHP),
        .cHP     (cHP),
        .aLN     (aLN),
        .bLN     (bLN),
        .cLN     (cLN),
        .deadAct (deadAct),
        .fault   (fault)
    );

    wire [2:0] hp_o = {cHP, bHP, aHP};
    wire [2:0] ln_o = {cLN, bLN, aLN};
    wire [8:0] obs  = {hp_o, ln_o, deadAct};
    localparam logic [8:0] ALL_OFF = {3'b111, 3'b000, 3'b000};

    // Reference model: a leg is on only when enable and its command have both
    // been sampled unchanged for DEAD_CYC+1 consecutive edges; any enabled leg
    // not yet on is in its dead interval.
    int         en_run;
    int         cmd_run [3];
    logic [2:0] last_cmd;

    always @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            en_run   <= 0;
            last_cmd <= 3'b000;
            for (int i = 0; i < 3; i++) cmd_run[i] <= 0;
        end else begin
            en_run <= outEn ? ((en_run < 1000) ? en_run + 1 : en_run) : 0;
            for (int i = 0; i < 3; i++)
                cmd_run[i] <= (phCmd[i] == last_cmd[i]) ? ((cmd_run[i] < 1000) ? cmd_run[i] + 1 : cmd_run[i]) : 1;
            last_cmd <= phCmd;
        end
    end

    function automatic logic [8:0] model_exp();
        logic [2:0] hp, ln, dd;
        for (int i = 0; i < 3; i++) begin
            logic on;
            on    = (en_run >= D + 1) && (cmd_run[i] >= D + 1);
            hp[i] = !(on && last_cmd[i]);
            ln[i] = on && !last_cmd[i];
            dd[i] = (en_run > 0) && !on;
        end
        return {hp, ln, dd};
    endfunction

    task automatic test_reset();
        nReset = 1'b0;
        outEn  = 1'b0;
        phCmd  = 3'b000;
        repeat (3) @(negedge clk50mhz);
        checks++;
        if (obs !== ALL_OFF || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset: got gates=%b fault=%b, want %b fault=0", obs, fault, ALL_OFF);
        end
        nReset = 1'b1;
        repeat (2) @(negedge clk50mhz);
        checks++;
        if (obs !== ALL_OFF) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, want %b", obs, ALL_OFF);
        end
    endtask

    task automatic test_enable();
        int first_on = -1;
        int dead_cnt = 0;
        phCmd = 3'b101;
        outEn = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk50mhz);
            checks++;
            if (obs !== model_exp() || fault !== 1'b0) begin
                errors++;
                $display("FAIL enable_cyc%0d: got %b fault=%b, want %b", i, obs, fault, model_exp());
            end
            if (deadAct == 3'b111) dead_cnt++;
            if (first_on < 0 && aHP == 1'b0 && bLN == 1'b1 && cHP == 1'b0) first_on = i;
        end
        checks++;
        if (first_on != D + 1 || dead_cnt != D) begin
            errors++;
            $display("FAIL enable_timing: on at %0d dead=%0d, want on at %0d dead=%0d", first_on, dead_cnt, D + 1, D);
        end
    endtask

    task automatic test_switch();
        int first_on = -1;
        phCmd[0] = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk50mhz);
            checks++;
            if (obs !== model_exp() || (!aHP && aLN)) begin
                errors++;
                $display("FAIL switch_cyc%0d: got %b, want %b", i, obs, model_exp());
            end
            if (i == 1) begin
                checks++;
                if (aHP !== 1'b1 || aLN !== 1'b0) begin
                    errors++;
                    $display("FAIL switch_off: got aHP=%b aLN=%b, want 1 0", aHP, aLN);
                end
            end
            if (first_on < 0 && aLN == 1'b1) first_on = i;
        end
        checks++;
        if (first_on != D + 1) begin
            errors++;
            $display("FAIL switch_timing: aLN on at %0d, want %0d", first_on, D + 1);
        end
    endtask

    task automatic test_retarget();
        int first_on = -1;
        phCmd[0] = 1'b1;
        repeat (60) @(negedge clk50mhz);
        phCmd[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk50mhz);
            checks++;
            if (obs !== model_exp()) begin
                errors++;
                $display("FAIL retarget_pre%0d: got %b, want %b", i, obs, model_exp());
            end
        end
        phCmd[0] = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk50mhz);
            checks++;
            if (obs !== model_exp()) begin
                errors++;
                $display("FAIL retarget_cyc%0d: got %b, want %b", i, obs, model_exp());
            end
            if (first_on < 0 && aHP == 1'b0) first_on = i;
        end
        checks++;
        if (first_on != D + 1) begin
            errors++;
            $display("FAIL retarget_timing: aHP on at %0d, want %0d", first_on, D + 1);
        end
    endtask

    task automatic test_disable();
        outEn = 1'b0;
        @(negedge clk50mhz);
        checks++;
        if (obs !== ALL_OFF) begin
            errors++;
            $display("FAIL disable_in_on: got %b, want %b", obs, ALL_OFF);
        end
        outEn = 1'b1;
        repeat (10) @(negedge clk50mhz);
        checks++;
        if (deadAct !== 3'b111) begin
            errors++;
            $display("FAIL disable_setup_dead: got deadAct=%b, want 111", deadAct);
        end
        outEn = 1'b0;
        @(negedge clk50mhz);
        checks++;
        if (obs !== ALL_OFF || obs !== model_exp()) begin
            errors++;
            $display("FAIL disable_in_dead: got %b, want %b", obs, ALL_OFF);
        end
    endtask

    task automatic test_reset_mid();
        int first_on = -1;
        phCmd = 3'b101;
        outEn = 1'b1;
        repeat (10) @(negedge clk50mhz);
        clk_run = 1'b0;
        #5 nReset = 1'b0;
        #1;
        checks++;
        if (obs !== ALL_OFF || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b fault=%b, want %b", obs, fault, ALL_OFF);
        end
        outEn = 1'b0;
        #20 nReset = 1'b1;
        clk_run = 1'b1;
        @(negedge clk50mhz);
        @(negedge clk50mhz);
        outEn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk50mhz);
            checks++;
            if (obs !== model_exp()) begin
                errors++;
                $display("FAIL reset_restart_cyc%0d: got %b, want %b", i, obs, model_exp());
            end
            if (first_on < 0 && aHP == 1'b0) first_on = i;
        end
        checks++;
        if (first_on != D + 1) begin
            errors++;
            $display("FAIL reset_restart_timing: on at %0d, want %0d", first_on, D + 1);
        end
    endtask

    task automatic test_random();
        int rate;
        for (int blk = 0; blk < 6; blk++) begin
            rate = $urandom_range(150, 15);
            for (int i = 0; i < 500; i++) begin
                @(negedge clk50mhz);
                checks++;
                if (obs !== model_exp() || fault !== 1'b0 || |(~hp_o & ln_o)) begin
                    errors++;
                    $display("FAIL random_b%0d_c%0d: got %b fault=%b, want %b", blk, i, obs, fault, model_exp());
                end
                if ($urandom_range(rate - 1, 0) == 0) phCmd[$urandom_range(2, 0)] ^= 1'b1;
                if ($urandom_range(299, 0) == 0) outEn = ~outEn;
            end
        end
    endtask

`ifdef SHOOT_THROUGH_CHECK_EN
    task automatic test_fault();
        outEn = 1'b1;
        repeat (5) @(negedge clk50mhz);
        force dut.hp_raw = 3'b110;
        force dut.ln_raw = 3'b001;
        @(negedge clk50mhz);
        release dut.hp_raw;
        release dut.ln_raw;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk50mhz);
            checks++;
            if (fault !== 1'b1 || obs !== ALL_OFF) begin
                errors++;
                $display("FAIL fault_hold%0d: got %b fault=%b, want %b fault=1", i, obs, fault, ALL_OFF);
            end
        end
        nReset = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got %b, want 0", fault);
        end
        @(negedge clk50mhz);
        nReset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_enable();
        test_switch();
        test_retarget();
        test_disable();
        test_reset_mid();
        test_random();
`ifdef SHOOT_THROUGH_CHECK_EN
        test_fault();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
